// File: rtl/ysyx_24110015_mem_arbiter.sv
// IFU/LSU arbiter onto a single memory port, with registered responses and timeout.
// Define MEM_ARB_RR_EN for round-robin tie-break; default build gives LSU fixed priority.
module ysyx_24110015_mem_arbiter #(
  parameter int ADDR_W  = 32,
  parameter int DATA_W  = 32,
  parameter int TIMEOUT = 255
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                ifu_req_valid,
  output logic                ifu_req_ready,
  input  logic [ADDR_W-1:0]   ifu_addr,
  output logic                ifu_resp_valid,
  output logic [DATA_W-1:0]   ifu_rdata,
  output logic                ifu_resp_err,
  input  logic                lsu_req_valid,
  output logic                lsu_req_ready,
  input  logic [ADDR_W-1:0]   lsu_addr,
  input  logic                lsu_wen,
  input  logic [DATA_W-1:0]   lsu_wdata,
  input  logic [DATA_W/8-1:0] lsu_wmask,
  output logic                lsu_resp_valid,
  output logic [DATA_W-1:0]   lsu_rdata,
  output logic                lsu_resp_err,
  output logic                mem_req_valid,
  input  logic                mem_req_ready,
  output logic [ADDR_W-1:0]   mem_addr,
  output logic                mem_wen,
  output logic [DATA_W-1:0]   mem_wdata,
  output logic [DATA_W/8-1:0] mem_wmask,
  input  logic                mem_resp_valid,
  input  logic [DATA_W-1:0]   mem_rdata
);

  localparam logic [15:0] TO_LAST = 16'(TIMEOUT - 1);

  typedef enum logic [2:0] {
    IDLE,
    REQ_IFU,
    REQ_LSU,
    WAIT_IFU,
    WAIT_LSU
  } state_t;

  state_t            state, state_nxt;
  logic [15:0]       cnt, cnt_nxt;
  logic              st_store, st_store_nxt;
  logic              lsu_tie_win;
  logic              done_ifu, done_lsu, done_err;
  logic [DATA_W-1:0] done_data;

`ifdef MEM_ARB_RR_EN
  // Remembers who was granted last; that master loses the next tie.
  logic last_ifu;

  always_ff @(posedge clk) begin
    if (rst)
      last_ifu <= 1'b1;
    else if (state == IDLE && state_nxt != IDLE)
      last_ifu <= (state_nxt == REQ_IFU);
  end

  assign lsu_tie_win = last_ifu;
`else
  assign lsu_tie_win = 1'b1;
`endif

  always_comb begin
    state_nxt     = state;
    cnt_nxt       = cnt;
    st_store_nxt  = st_store;
    mem_req_valid = 1'b0;
    mem_addr      = '0;
    mem_wen       = 1'b0;
    mem_wdata     = '0;
    mem_wmask     = '0;
    ifu_req_ready = 1'b0;
    lsu_req_ready = 1'b0;
    done_ifu      = 1'b0;
    done_lsu      = 1'b0;
    done_err      = 1'b0;
    done_data     = '0;
    unique case (state)
      IDLE: begin
        if (lsu_req_valid && (!ifu_req_valid || lsu_tie_win))
          state_nxt = REQ_LSU;
        else if (ifu_req_valid)
          state_nxt = REQ_IFU;
      end
      REQ_IFU: begin
        mem_req_valid = ifu_req_valid;
        mem_addr      = ifu_addr;
        ifu_req_ready = mem_req_ready;
        if (!ifu_req_valid) begin
          state_nxt = IDLE;
        end else if (mem_req_ready) begin
          state_nxt = WAIT_IFU;
          cnt_nxt   = '0;
        end
      end
      REQ_LSU: begin
        mem_req_valid = lsu_req_valid;
        mem_addr      = lsu_addr;
        mem_wen       = lsu_wen;
        mem_wdata     = lsu_wdata;
        mem_wmask     = lsu_wmask;
        lsu_req_ready = mem_req_ready;
        if (!lsu_req_valid) begin
          state_nxt = IDLE;
        end else if (mem_req_ready) begin
          state_nxt    = WAIT_LSU;
          cnt_nxt      = '0;
          st_store_nxt = lsu_wen;
        end
      end
      WAIT_IFU: begin
        if (mem_resp_valid) begin
          done_ifu  = 1'b1;
          done_data = mem_rdata;
          state_nxt = IDLE;
        end else if (cnt == TO_LAST) begin
          done_ifu  = 1'b1;
          done_err  = 1'b1;
          state_nxt = IDLE;
        end else begin
          cnt_nxt = cnt + 16'd1;
        end
      end
      WAIT_LSU: begin
        if (mem_resp_valid) begin
          done_lsu  = 1'b1;
          done_data = st_store ? '0 : mem_rdata;
          state_nxt = IDLE;
        end else if (cnt == TO_LAST) begin
          done_lsu  = 1'b1;
          done_err  = 1'b1;
          state_nxt = IDLE;
        end else begin
          cnt_nxt = cnt + 16'd1;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state          <= IDLE;
      cnt            <= '0;
      st_store       <= 1'b0;
      ifu_resp_valid <= 1'b0;
      ifu_rdata      <= '0;
      ifu_resp_err   <= 1'b0;
      lsu_resp_valid <= 1'b0;
      lsu_rdata      <= '0;
      lsu_resp_err   <= 1'b0;
    end else begin
      state          <= state_nxt;
      cnt            <= cnt_nxt;
      st_store       <= st_store_nxt;
      ifu_resp_valid <= done_ifu;
      ifu_rdata      <= done_ifu ? done_data : '0;
      ifu_resp_err   <= done_ifu & done_err;
      lsu_resp_valid <= done_lsu;
      lsu_rdata      <= done_lsu ? done_data : '0;
      lsu_resp_err   <= done_lsu & done_err;
    end
  end

endmodule

// File: tb/tb_ysyx_24110015_mem_arbiter.sv
// Bench for ysyx_24110015_mem_arbiter: directed cases, then random traffic.
// A transaction-level model predicts every output on every cycle.
module tb_ysyx_24110015_mem_arbiter;

  localparam int TO = 4;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst;
  logic        ifu_req_valid, ifu_req_ready;
  logic [31:0] ifu_addr;
  logic        ifu_resp_valid, ifu_resp_err;
  logic [31:0] ifu_rdata;
  logic        lsu_req_valid, lsu_req_ready;
  logic [31:0] lsu_addr;
  logic        lsu_wen;
  logic [31:0] lsu_wdata;
  logic [3:0]  lsu_wmask;
  logic        lsu_resp_valid, lsu_resp_err;
  logic [31:0] lsu_rdata;
  logic        mem_req_valid, mem_req_ready;
  logic [31:0] mem_addr;
  logic        mem_wen;
  logic [31:0] mem_wdata;
  logic [3:0]  mem_wmask;
  logic        mem_resp_valid;
  logic [31:0] mem_rdata;

  ysyx_24110015_mem_arbiter #(
    .ADDR_W (32),
    .DATA_W (32),
    .TIMEOUT(TO)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .ifu_req_valid (ifu_req_valid),
    .ifu_req_ready (ifu_req_ready),
    .ifu_addr      (ifu_addr),
    .ifu_resp_valid(ifu_resp_valid),
    .ifu_rdata     (ifu_rdata),
    .ifu_resp_err  (ifu_resp_err),
    .lsu_req_valid (lsu_req_valid),
    .lsu_req_ready (lsu_req_ready),
    .lsu_addr      (lsu_addr),
    .lsu_wen       (lsu_wen),
    .lsu_wdata     (lsu_wdata),
    .lsu_wmask     (lsu_wmask),
    .lsu_resp_valid(lsu_resp_valid),
    .lsu_rdata     (lsu_rdata),
    .lsu_resp_err  (lsu_resp_err),
    .mem_req_valid (mem_req_valid),
    .mem_req_ready (mem_req_ready),
    .mem_addr      (mem_addr),
    .mem_wen       (mem_wen),
    .mem_wdata     (mem_wdata),
    .mem_wmask     (mem_wmask),
    .mem_resp_valid(mem_resp_valid),
    .mem_rdata     (mem_rdata)
  );

  int n_vec = 0;
  int n_bad = 0;

  function automatic void chk(string name, logic [31:0] act, logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
    end
  endfunction

  // Model: owner 0=none 1=IFU 2=LSU; issued once memory took the request.
  int          owner = 0;
  bit          issued = 1'b0;
  bit          was_store = 1'b0;
  bit          last_ifu = 1'b1;
  bit          lsu_first;
  int          cyc = 0;
  int          issued_cyc = 0;
  logic        e_ifu_rv = 1'b0, e_ifu_err = 1'b0;
  logic        e_lsu_rv = 1'b0, e_lsu_err = 1'b0;
  logic [31:0] e_ifu_rd = '0, e_lsu_rd = '0;

  function automatic void deliver(int who, logic [31:0] d, logic err);
    if (who == 1) begin
      e_ifu_rv = 1'b1; e_ifu_rd = d; e_ifu_err = err;
    end else begin
      e_lsu_rv = 1'b1; e_lsu_rd = d; e_lsu_err = err;
    end
    owner  = 0;
    issued = 1'b0;
  endfunction

  initial forever begin
    @(posedge clk);
    cyc++;
    e_ifu_rv = 1'b0; e_ifu_rd = '0; e_ifu_err = 1'b0;
    e_lsu_rv = 1'b0; e_lsu_rd = '0; e_lsu_err = 1'b0;
    if (rst) begin
      owner    = 0;
      issued   = 1'b0;
      last_ifu = 1'b1;
    end else if (owner == 0) begin
      if (ifu_req_valid || lsu_req_valid) begin
`ifdef MEM_ARB_RR_EN
        lsu_first = last_ifu;
`else
        lsu_first = 1'b1;
`endif
        owner    = (lsu_req_valid && (!ifu_req_valid || lsu_first)) ? 2 : 1;
        last_ifu = (owner == 1);
      end
    end else if (!issued) begin
      if (!(owner == 1 ? ifu_req_valid : lsu_req_valid)) begin
        owner = 0;
      end else if (mem_req_ready) begin
        issued     = 1'b1;
        issued_cyc = cyc;
        was_store  = (owner == 2) && lsu_wen;
      end
    end else if (mem_resp_valid) begin
      deliver(owner, was_store ? 32'h0 : mem_rdata, 1'b0);
    end else if (cyc - issued_cyc >= TO) begin
      deliver(owner, 32'h0, 1'b1);
    end
  end

  initial forever begin
    bit rq, ev;
    @(negedge clk);
    rq = (owner != 0) && !issued;
    ev = rq && (owner == 1 ? ifu_req_valid : lsu_req_valid);
    chk("mem_req_valid", 32'(mem_req_valid), 32'(ev));
    chk("ifu_req_ready", 32'(ifu_req_ready), 32'(rq && owner == 1 && mem_req_ready));
    chk("lsu_req_ready", 32'(lsu_req_ready), 32'(rq && owner == 2 && mem_req_ready));
    if (ev && owner == 1) begin
      chk("mem_addr", mem_addr, ifu_addr);
      chk("mem_wen", 32'(mem_wen), 32'h0);
      chk("mem_wdata", mem_wdata, 32'h0);
      chk("mem_wmask", 32'(mem_wmask), 32'h0);
    end else if (ev) begin
      chk("mem_addr", mem_addr, lsu_addr);
      chk("mem_wen", 32'(mem_wen), 32'(lsu_wen));
      chk("mem_wdata", mem_wdata, lsu_wdata);
      chk("mem_wmask", 32'(mem_wmask), 32'(lsu_wmask));
    end
    chk("ifu_resp_valid", 32'(ifu_resp_valid), 32'(e_ifu_rv));
    chk("ifu_resp_err", 32'(ifu_resp_err), 32'(e_ifu_err));
    chk("lsu_resp_valid", 32'(lsu_resp_valid), 32'(e_lsu_rv));
    chk("lsu_resp_err", 32'(lsu_resp_err), 32'(e_lsu_err));
    if (e_ifu_rv) chk("ifu_rdata", ifu_rdata, e_ifu_rd);
    if (e_lsu_rv) chk("lsu_rdata", lsu_rdata, e_lsu_rd);
  end

  // Stimulus side: masters drop valid after a handshake; memory may auto-reply.
  bit          s_ifu_hs, s_lsu_hs, s_mem_hs;
  bit          s_ifu_rv, s_ifu_err, s_lsu_rv, s_lsu_err;
  logic [31:0] s_ifu_rd, s_lsu_rd;
  bit          mem_auto = 1'b0;
  logic [31:0] auto_rdata = '0;

  task automatic sample();
    @(negedge clk);
    s_ifu_hs  = ifu_req_valid & ifu_req_ready;
    s_lsu_hs  = lsu_req_valid & lsu_req_ready;
    s_mem_hs  = mem_req_valid & mem_req_ready;
    s_ifu_rv  = ifu_resp_valid; s_ifu_rd = ifu_rdata; s_ifu_err = ifu_resp_err;
    s_lsu_rv  = lsu_resp_valid; s_lsu_rd = lsu_rdata; s_lsu_err = lsu_resp_err;
    @(posedge clk);
    #1;
  endtask

  task automatic tick();
    sample();
    if (s_ifu_hs) ifu_req_valid = 1'b0;
    if (s_lsu_hs) lsu_req_valid = 1'b0;
    mem_resp_valid = s_mem_hs && mem_auto;
    mem_rdata      = auto_rdata;
  endtask

  task automatic rand_tick();
    sample();
    rst = ($urandom_range(0, 149) == 0);
    if (s_ifu_hs || (ifu_req_valid && $urandom_range(0, 19) == 0)) begin
      ifu_req_valid = 1'b0;
    end else if (!ifu_req_valid && $urandom_range(0, 2) == 0) begin
      ifu_req_valid = 1'b1;
      ifu_addr      = $urandom;
    end
    if (s_lsu_hs || (lsu_req_valid && $urandom_range(0, 19) == 0)) begin
      lsu_req_valid = 1'b0;
    end else if (!lsu_req_valid && $urandom_range(0, 2) == 0) begin
      lsu_req_valid = 1'b1;
      lsu_addr      = $urandom;
      lsu_wen       = 1'($urandom_range(0, 1));
      lsu_wdata     = $urandom;
      lsu_wmask     = 4'($urandom_range(0, 15));
    end
    mem_req_ready  = ($urandom_range(0, 2) != 0);
    mem_resp_valid = ($urandom_range(0, 3) == 0);
    mem_rdata      = $urandom;
  endtask

  task automatic wait_resp(input bit lsu, input int max, output int lat,
                           output logic [31:0] rd, output logic err);
    lat = -1; rd = '0; err = 1'b0;
    for (int i = 0; i < max; i++) begin
      tick();
      if (lsu ? s_lsu_rv : s_ifu_rv) begin
        lat = i;
        rd  = lsu ? s_lsu_rd : s_ifu_rd;
        err = lsu ? s_lsu_err : s_ifu_err;
        break;
      end
    end
    if (lat < 0) begin
      n_vec++;
      n_bad++;
      $display("FAIL wait_resp(lsu=%0d): no response within %0d cycles", lsu, max);
    end
  endtask

  initial begin
    int          lat, n_i, n_l;
    logic [31:0] rd;
    logic        err;
    rst = 1'b1;
    ifu_req_valid = 1'b1; ifu_addr = 32'h8000_0000;
    lsu_req_valid = 1'b1; lsu_addr = 32'h8000_1000;
    lsu_wen = 1'b1; lsu_wdata = 32'h1; lsu_wmask = 4'hF;
    mem_req_ready = 1'b1; mem_resp_valid = 1'b0; mem_rdata = '0;
    repeat (2) begin
      @(negedge clk);
      chk("reset_outs", {ifu_req_ready, ifu_resp_valid, ifu_resp_err,
                         lsu_req_ready, lsu_resp_valid, lsu_resp_err,
                         mem_req_valid, mem_wen, mem_wmask}, 32'h0);
      chk("reset_rdata", ifu_rdata | lsu_rdata | mem_addr | mem_wdata, 32'h0);
    end
    @(posedge clk);
    #1;
    rst = 1'b0; ifu_req_valid = 1'b0; lsu_req_valid = 1'b0;
    tick();

    // IFU fetch against zero-wait memory
    mem_auto = 1'b1; auto_rdata = 32'h0010_0073;
    ifu_addr = 32'h8000_0000; ifu_req_valid = 1'b1;
    #2 chk("idle_no_fwd", 32'(mem_req_valid), 32'h0);
    wait_resp(1'b0, 20, lat, rd, err);
    chk("ifu_latency", lat, 3);
    chk("ifu_rdata_lit", rd, 32'h0010_0073);
    chk("ifu_err_lit", 32'(err), 32'h0);

    // Simultaneous requests: LSU store first, then a second tie
    lsu_addr = 32'h8000_1000; lsu_wen = 1'b1;
    lsu_wdata = 32'hDEAD_BEEF; lsu_wmask = 4'hF;
    ifu_addr = 32'h8000_0004; auto_rdata = 32'h1234_5678;
    ifu_req_valid = 1'b1; lsu_req_valid = 1'b1;
    tick();
    #2;
    chk("tie_mem_wen", 32'(mem_wen), 32'h1);
    chk("tie_mem_addr", mem_addr, 32'h8000_1000);
    chk("tie_mem_wdata", mem_wdata, 32'hDEAD_BEEF);
    chk("tie_ifu_ready", 32'(ifu_req_ready), 32'h0);
    tick();
    lsu_wen = 1'b0; lsu_addr = 32'h8000_1004; lsu_req_valid = 1'b1;
    tick();
    tick();
    chk("store_resp_valid", 32'(s_lsu_rv), 32'h1);
    chk("store_rdata_zero", s_lsu_rd, 32'h0);
    #2;
`ifdef MEM_ARB_RR_EN
    chk("tie2_addr", mem_addr, 32'h8000_0004);
`else
    chk("tie2_addr", mem_addr, 32'h8000_1004);
`endif
    n_i = 0; n_l = 0;
    repeat (12) begin
      tick();
      n_i += int'(s_ifu_rv);
      n_l += int'(s_lsu_rv);
    end
    chk("tie2_ifu_served", n_i, 1);
    chk("tie2_lsu_served", n_l, 1);

    // LSU load into a silent memory times out
    mem_auto = 1'b0;
    lsu_addr = 32'h8000_2000; lsu_wen = 1'b0; lsu_req_valid = 1'b1;
    wait_resp(1'b1, 20, lat, rd, err);
    chk("to_latency", lat, 2 + TO);
    chk("to_err", 32'(err), 32'h1);
    chk("to_rdata", rd, 32'h0);
    mem_auto = 1'b1; auto_rdata = 32'hCAFE_F00D;
    ifu_addr = 32'h8000_0008; ifu_req_valid = 1'b1;
    wait_resp(1'b0, 20, lat, rd, err);
    chk("after_to_lat", lat, 3);
    chk("after_to_rdata", rd, 32'hCAFE_F00D);

    // Memory holds off IFU for five cycles
    mem_req_ready = 1'b0;
    ifu_addr = 32'h8000_0010; ifu_req_valid = 1'b1;
    tick();
    lsu_addr = 32'h8000_3000; lsu_wen = 1'b0; lsu_req_valid = 1'b1;
    for (int k = 0; k < 5; k++) begin
      #2;
      chk("stall_ifu_ready", 32'(ifu_req_ready), 32'h0);
      chk("stall_lsu_ready", 32'(lsu_req_ready), 32'h0);
      chk("stall_addr", mem_addr, 32'h8000_0010);
      chk("stall_valid", 32'(mem_req_valid), 32'h1);
      tick();
    end
    mem_req_ready = 1'b1; auto_rdata = 32'h0BAD_F00D;
    #2;
    chk("stall_hs_ifu", 32'(ifu_req_ready), 32'h1);
    chk("stall_hs_lsu", 32'(lsu_req_ready), 32'h0);
    wait_resp(1'b0, 20, lat, rd, err);
    chk("stall_ifu_rdata", rd, 32'h0BAD_F00D);
    wait_resp(1'b1, 20, lat, rd, err);
    chk("stall_lsu_rdata", rd, 32'h0BAD_F00D);

    // Reset while LSU waits; the late response must be dropped
    mem_auto = 1'b0;
    lsu_addr = 32'h8000_4000; lsu_wen = 1'b0; lsu_req_valid = 1'b1;
    tick();
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0; mem_resp_valid = 1'b1; mem_rdata = 32'h1111_1111;
    #2 chk("rst_idle", 32'(mem_req_valid), 32'h0);
    repeat (4) begin
      tick();
      chk("rst_no_resp", 32'(s_lsu_rv | s_ifu_rv), 32'h0);
    end

    repeat (3000) rand_tick();

    rst = 1'b0; ifu_req_valid = 1'b0; lsu_req_valid = 1'b0;
    mem_resp_valid = 1'b0;
    repeat (10) sample();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
